// File: rtl/alu_pkg.sv
// Shared ALU control codes and execute-stage FSM encoding, used by both the
// ALU decoder and the multi-cycle execute ALU.
package alu_pkg;

  localparam logic [2:0] ALUCTL_AND = 3'b000;
  localparam logic [2:0] ALUCTL_OR  = 3'b001;
  localparam logic [2:0] ALUCTL_ADD = 3'b010;
  localparam logic [2:0] ALUCTL_MUL = 3'b101;
  localparam logic [2:0] ALUCTL_SUB = 3'b110;
  localparam logic [2:0] ALUCTL_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DONE = 2'b10
  } alu_state_e;

  // Case equality so that an X code never reads as a MUL request.
  function automatic logic is_mul_op(input logic [2:0] ctl);
    return (ctl === ALUCTL_MUL);
  endfunction

endpackage

// File: rtl/seq_mult.sv
// Iterative shift-add multiplier: one partial product per cycle, fixed WIDTH
// iterations, low WIDTH bits of the product kept.
module seq_mult #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  logic             busy_q, busy_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
  logic             last_s;

  // done marks the final iteration; the full product is in acc_q after this edge.
  assign last_s  = busy_q && (cnt_q == CNTW'(WIDTH - 1));
  assign busy    = busy_q;
  assign done    = last_s;
  assign product = acc_q;

  // Next-state for the shift-add datapath and iteration counter.
  always_comb begin
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    if (abort) begin
      busy_d = 1'b0;
    end else if (start) begin
      busy_d  = 1'b1;
      cnt_d   = {CNTW{1'b0}};
      acc_d   = {WIDTH{1'b0}};
      mcand_d = a;
      mplr_d  = b;
    end else if (busy_q) begin
      if (mplr_q[0]) begin
        acc_d = acc_q + mcand_q;
      end else begin
        acc_d = acc_q;
      end
      mcand_d = {mcand_q[WIDTH-2:0], 1'b0};
      mplr_d  = {1'b0, mplr_q[WIDTH-1:1]};
      cnt_d   = cnt_q + CNTW'(1);
      busy_d  = !last_s;
    end else begin
      busy_d = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q  <= 1'b0;
      cnt_q   <= {CNTW{1'b0}};
      acc_q   <= {WIDTH{1'b0}};
      mcand_q <= {WIDTH{1'b0}};
      mplr_q  <= {WIDTH{1'b0}};
    end else begin
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
    end
  end

endmodule

// File: rtl/alu_mc_exec.sv
// Execute-stage ALU: single-cycle logic/arithmetic ops plus a stalling
// iterative MUL driven by a three-state issue/run/present FSM.
module alu_mc_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNTW  = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic             flush,
  input  logic [2:0]       alucontrol,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             stall,
  output logic             done
);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] comb_res_s;
  logic             issue_s;
  logic             abort_s;
  logic             mult_busy_s;
  logic             mult_done_s;
  logic [WIDTH-1:0] mult_prod_s;

  // Reset gating keeps stall low while the core is held in reset.
  assign issue_s = (state_q == ST_IDLE) && valid_i && is_mul_op(alucontrol)
                   && !flush && !reset;
  assign abort_s = (state_q == ST_MUL) && flush;

  seq_mult #(
    .WIDTH (WIDTH),
    .CNTW  (CNTW)
  ) u_seq_mult (
    .clk     (clk),
    .reset   (reset),
    .start   (issue_s),
    .abort   (abort_s),
    .a       (srca),
    .b       (srcb),
    .busy    (mult_busy_s),
    .done    (mult_done_s),
    .product (mult_prod_s)
  );

  // Single-cycle operation mux; MUL and undefined codes yield zero here.
  always_comb begin
    comb_res_s = {WIDTH{1'b0}};
    case (alucontrol)
      ALUCTL_AND: comb_res_s = srca & srcb;
      ALUCTL_OR:  comb_res_s = srca | srcb;
      ALUCTL_ADD: comb_res_s = srca + srcb;
      ALUCTL_SUB: comb_res_s = srca - srcb;
      ALUCTL_SLT: comb_res_s = {{(WIDTH-1){1'b0}}, ($signed(srca) < $signed(srcb))};
      default:    comb_res_s = {WIDTH{1'b0}};
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; DONE never re-arms, so a held MUL cannot retrigger there.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (issue_s) begin
          state_d = ST_MUL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (mult_done_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_MUL;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    result = {WIDTH{1'b0}};
    stall  = 1'b0;
    done   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stall = issue_s;
        if (issue_s) begin
          result = {WIDTH{1'b0}};
        end else begin
          result = comb_res_s;
        end
      end
      ST_MUL: begin
        stall  = 1'b1;
        result = {WIDTH{1'b0}};
      end
      ST_DONE: begin
        done   = 1'b1;
        result = mult_prod_s;
      end
      default: begin
        result = {WIDTH{1'b0}};
      end
    endcase
  end

  assign zero = (result == {WIDTH{1'b0}});

endmodule

// File: tb/tb_alu_mc_exec.sv
// Scoreboard bench for alu_mc_exec: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them and flags unexpected done pulses.
module tb_alu_mc_exec;
  import alu_pkg::*;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             valid_i;
  logic             flush;
  logic [2:0]       alucontrol;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             stall;
  logic             done;

  alu_mc_exec #(.WIDTH(WIDTH), .CNTW(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_i    (valid_i),
    .flush      (flush),
    .alucontrol (alucontrol),
    .srca       (srca),
    .srcb       (srcb),
    .result     (result),
    .zero       (zero),
    .stall      (stall),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               cyc;
    string            name;
    logic [WIDTH-1:0] res;
    logic             z;
    logic             st;
    logic             dn;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input string name, input logic [WIDTH-1:0] res,
                      input logic st, input logic dn);
    exp_t e;
    e.cyc  = cyc;
    e.name = name;
    e.res  = res;
    e.z    = (res == 32'd0);
    e.st   = st;
    e.dn   = dn;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] ctl, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b);
    valid_i    = 1'b1;
    alucontrol = ctl;
    srca       = a;
    srcb       = b;
  endtask

  // Full MUL from C0 to C33 with inputs held; returns in the DONE cycle.
  task automatic mul_op(input string name, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp_res);
    drive(ALUCTL_MUL, a, b);
    push({name, "_c0"}, 32'd0, 1'b1, 1'b0);
    for (int i = 1; i <= WIDTH; i++) begin
      step();
      push({name, "_run"}, 32'd0, 1'b1, 1'b0);
    end
    step();
    push({name, "_done"}, exp_res, 1'b0, 1'b1);
  endtask

  // Monitor: compare every expectation due this cycle; any done pulse must be expected.
  always @(negedge clk) begin
    bit done_expected;
    done_expected = 1'b0;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        errors++;
        $display("FAIL %s: check missed at cycle %0d (due %0d)", e.name, cyc, e.cyc);
      end else begin
        if (e.dn) done_expected = 1'b1;
        if (result !== e.res || zero !== e.z || stall !== e.st || done !== e.dn) begin
          errors++;
          $display("FAIL %s: cyc=%0d got result=%h zero=%b stall=%b done=%b, expected result=%h zero=%b stall=%b done=%b",
                   e.name, cyc, result, zero, stall, done, e.res, e.z, e.st, e.dn);
        end
      end
    end
    if (done === 1'b1 && !done_expected) begin
      checks++;
      errors++;
      $display("FAIL unexpected_done: cyc=%0d got done=1, expected done=0", cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    reset      = 1'b1;
    valid_i    = 1'b0;
    flush      = 1'b0;
    alucontrol = ALUCTL_AND;
    srca       = 32'd0;
    srcb       = 32'd0;

    // During reset: combinational result, no stall, even with a MUL presented.
    step();
    drive(ALUCTL_ADD, 32'd5, 32'd7);
    push("reset_add", 32'd12, 1'b0, 1'b0);
    step();
    drive(ALUCTL_MUL, 32'd3, 32'd3);
    push("reset_mul_gated", 32'd0, 1'b0, 1'b0);
    step();
    reset   = 1'b0;
    valid_i = 1'b0;
    alucontrol = ALUCTL_AND;
    step();

    // Single-cycle ops.
    drive(ALUCTL_ADD, 32'd5, 32'd7);                 push("add", 32'd12, 1'b0, 1'b0);
    step(); drive(ALUCTL_SUB, 32'd3, 32'd3);         push("sub_zero", 32'd0, 1'b0, 1'b0);
    step(); drive(ALUCTL_SLT, 32'hFFFF_FFFF, 32'd1); push("slt_neg", 32'd1, 1'b0, 1'b0);
    step(); drive(ALUCTL_SLT, 32'd1, 32'hFFFF_FFFF); push("slt_pos", 32'd0, 1'b0, 1'b0);
    step(); drive(3'b100, 32'd9, 32'd4);             push("undef_100", 32'd0, 1'b0, 1'b0);
    step(); drive(ALUCTL_AND, 32'hF0F0_1234, 32'hFF00_FFFF); push("and", 32'hF000_1234, 1'b0, 1'b0);
    step(); drive(ALUCTL_OR, 32'hF0F0_0000, 32'h0F00_0001);  push("or", 32'hFFF0_0001, 1'b0, 1'b0);
    step(); drive(ALUCTL_ADD, 32'hFFFF_FFFF, 32'd1);  push("add_wrap", 32'd0, 1'b0, 1'b0);
    step(); drive(ALUCTL_SUB, 32'd0, 32'd1);          push("sub_wrap", 32'hFFFF_FFFF, 1'b0, 1'b0);
    // Flush in IDLE suppresses the issue.
    step(); drive(ALUCTL_MUL, 32'd2, 32'd2); flush = 1'b1;
    push("idle_flush_mul", 32'd0, 1'b0, 1'b0);
    step(); flush = 1'b0; drive(ALUCTL_ADD, 32'd2, 32'd2);
    push("after_idle_flush", 32'd4, 1'b0, 1'b0);
    step();

    // MUL latency with held inputs.
    mul_op("mul_1234", 32'h0000_1234, 32'h10, 32'h0001_2340);
    step(); drive(ALUCTL_ADD, 32'd1, 32'd2); push("post_mul_add", 32'd3, 1'b0, 1'b0);
    step();

    // Back-to-back MULs: second issues in the IDLE cycle after DONE.
    mul_op("mul_wrap", 32'h8000_0000, 32'd2, 32'd0);
    step();
    mul_op("mul_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);
    step(); valid_i = 1'b0; alucontrol = ALUCTL_AND;
    step();

    // Flush mid-MUL at C10.
    drive(ALUCTL_MUL, 32'd3, 32'd5);
    push("flush_c0", 32'd0, 1'b1, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 10) flush = 1'b1;
      push("flush_run", 32'd0, 1'b1, 1'b0);
    end
    step(); flush = 1'b0; drive(ALUCTL_ADD, 32'd1, 32'd1);
    push("flush_add", 32'd2, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      step(); push("flush_quiet", 32'd2, 1'b0, 1'b0);
    end
    step(); valid_i = 1'b0; alucontrol = ALUCTL_AND; srca = 32'd0; srcb = 32'd0;
    step();

    // Async reset mid-MUL at C15, between edges.
    drive(ALUCTL_MUL, 32'd9, 32'd9);
    push("rst_c0", 32'd0, 1'b1, 1'b0);
    for (int i = 1; i < 15; i++) begin
      step(); push("rst_run", 32'd0, 1'b1, 1'b0);
    end
    step();
    #1;
    reset   = 1'b1;
    valid_i = 1'b0;
    push("rst_async", 32'd0, 1'b0, 1'b0);
    #5;
    reset = 1'b0;
    step();
    push("rst_idle", 32'd0, 1'b0, 1'b0);
    step();
    mul_op("mul_6x7", 32'd6, 32'd7, 32'd42);
    step(); valid_i = 1'b0; alucontrol = ALUCTL_AND; srca = 32'd0; srcb = 32'd0;
    push("final_idle", 32'd0, 1'b0, 1'b0);
    step();
    step();

    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_mc_exec.md
Name: alu_mc_exec

Overview:
- Execute-stage ALU for the pipelined MIPS core.
- Consumes the 3-bit alucontrol code produced by the ALU decoder and produces result and zero for the EX/MEM register.
- AND/OR/ADD/SUB/SLT complete in the issue cycle.
- MUL runs on an iterative shift-add multiplier and holds the pipeline through a stall output to the hazard unit.

Parameters:
- WIDTH, 32, datapath width in bits.
- CNTW, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- valid_i  input  1  EX stage holds a live instruction.
- flush  input  1  synchronous abort of an in-flight MUL (branch/exception flush).
- alucontrol  input  3  operation code from the ALU decoder.
- srca  input  WIDTH  operand A.
- srcb  input  WIDTH  operand B.
- result  output  WIDTH  operation result.
- zero  output  1  high when result equals 0.
- stall  output  1  hazard unit must freeze IF/ID/EX and bubble MEM.
- done  output  1  one-cycle pulse when a MUL result is presented.

Behaviour:
- Reset: state=IDLE, counter=0, accumulator/multiplicand/multiplier registers=0. Outputs: stall=0, done=0, result equals the combinational value of the current inputs.
- Codes:
  - 000 AND.
  - 001 OR.
  - 010 ADD (wraps, no overflow trap).
  - 110 SUB (wraps).
  - 111 SLT: signed compare, result = {WIDTH-1 zeros, srca<srcb}.
  - 101 MUL: low WIDTH bits of the product, which are identical for signed and unsigned operands; upper bits discarded.
  - 011, 100 and X: result=0.
- Single-cycle ops: combinational in IDLE. stall=0, done=0, zero=(result==0). No state change.
- State IDLE:
  - Transition trigger: valid_i=1 and alucontrol=101 (issue cycle, call it C0).
  - In C0: stall=1 combinationally, result=0.
  - At the C0 edge: latch srca into the multiplicand, srcb into the multiplier, accumulator=0, counter=0, then go to MUL.
- State MUL:
  - Each cycle: if multiplier[0], accumulator += multiplicand (mod 2^WIDTH); multiplicand <<= 1; multiplier >>= 1; counter++.
  - Fixed latency; there is no early termination.
  - After WIDTH iterations, i.e. cycles C1..C32 for WIDTH=32, go to DONE.
  - stall=1 and result=0 throughout.
  - Inputs are ignored; the pipeline holds them stable.
- State DONE (C33):
  - result = accumulator, stall=0, done=1.
  - valid_i/alucontrol still show the same MUL and must NOT retrigger.
  - Next state is IDLE unconditionally.
- Total stall: WIDTH+1 cycles per MUL.
- Back-to-back MULs: the second issues in the IDLE cycle following DONE.
- flush:
  - In MUL: next state IDLE; stall drops the cycle after flush is sampled; no done pulse.
  - In DONE: done still pulses and next state is IDLE.
  - In IDLE: suppresses a MUL issue (no transition); single-cycle ops are unaffected.
- Reset mid-MUL: state returns to IDLE immediately and asynchronously; stall=0; no done pulse.
- zero is always derived from result. It is 1 while stall=1; consumers gate it with stall.

Decomposition:
- Shared package alu_pkg:
  - ALUCTL_AND=3'b000, ALUCTL_OR=3'b001, ALUCTL_ADD=3'b010, ALUCTL_MUL=3'b101, ALUCTL_SUB=3'b110, ALUCTL_SLT=3'b111.
  - State encoding ST_IDLE/ST_MUL/ST_DONE.
  - The decoder and this block both use the alucontrol constants.
- Sub-module seq_mult:
  - Contains the iterative shift-add datapath and counter.
  - Interface: start, abort, a, b, busy, done, product.
- alu_mc_exec:
  - Holds the FSM/stall logic and the combinational op mux.

Test Plan:
- ADD/SUB/zero: alucontrol=010, srca=5, srcb=7 -> result=12, zero=0, stall=0 in same cycle. Then 110, 3, 3 -> result=0, zero=1.
- SLT signed: 111, srca=32'hFFFF_FFFF, srcb=1 -> result=1. Then srca=1, srcb=32'hFFFF_FFFF -> result=0. Undefined code 100 -> result=0.
- MUL latency: 101, srca=32'h0000_1234, srcb=32'h10 issued at C0:
  - stall=1 for C0..C32.
  - At C33: done=1, stall=0, result=32'h0001_2340.
  - Holding the inputs through C33 produces no retrigger.
- MUL wrap/back-to-back: 32'h8000_0000*2 -> result=0, zero=1. Immediately followed by 32'hFFFF_FFFF*32'hFFFF_FFFF -> result=1, done at C33 of the second op.
- Flush mid-MUL: flush=1 at C10 -> stall=0 from C11, done never pulses. A following ADD 1+1 -> 2 with no stall.
- Async reset mid-MUL: reset pulsed between edges at C15 -> stall falls without a clock edge, state IDLE. After release, MUL 6*7 -> 42 at C33.
